// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer_pkg
// Purpose  : Shared definitions for the fetch sequencer and its redirect
//            decode. These are also used by the fetch/decode register flush
//            logic.
// Contents : NOP encoding, FSM state encoding, execute-stage PC-select codes.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_sequencer_pkg;

   // addi x0, x0, 0 : presented whenever no real instruction is available
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      HOLD  = 3'd3,
      DRAIN = 3'd4
   } fetch_state_e;

   typedef enum logic [1:0] {
      SEL_SEQ  = 2'b00,
      SEL_BR   = 2'b01,
      SEL_JAL  = 2'b10,
      SEL_JALR = 2'b11
   } pc_sel_e;

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer_if
// Purpose  : Bundles the signals between the fetch sequencer and its
//            surroundings (execute redirect, back-end stall, instruction
//            cache read port, fetch/decode register).
// Modports : master - the fetch sequencer itself
//            slave  - the environment (cache, execute stage, pipeline reg)
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_sequencer_if #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDRESS_BITS = 20
) ();

   // Back end / execute stage
   logic                    stall;
   logic [1:0]              next_PC_select_execute;
   logic                    branch_execute;
   logic [ADDRESS_BITS-1:0] redirect_target_execute;

   // Instruction cache read port
   logic                    icache_ready;
   logic                    icache_valid;
   logic [DATA_WIDTH-1:0]   icache_instruction;
   logic                    icache_read;
   logic [ADDRESS_BITS-1:0] icache_address;

   // Toward the fetch/decode pipeline register
   logic [ADDRESS_BITS-1:0] inst_PC_fetch;
   logic [DATA_WIDTH-1:0]   instruction_fetch;
   logic                    fetch_valid;

   modport master (
      input  stall,
      input  next_PC_select_execute,
      input  branch_execute,
      input  redirect_target_execute,
      input  icache_ready,
      input  icache_valid,
      input  icache_instruction,
      output icache_read,
      output icache_address,
      output inst_PC_fetch,
      output instruction_fetch,
      output fetch_valid
   );

   modport slave (
      output stall,
      output next_PC_select_execute,
      output branch_execute,
      output redirect_target_execute,
      output icache_ready,
      output icache_valid,
      output icache_instruction,
      input  icache_read,
      input  icache_address,
      input  inst_PC_fetch,
      input  instruction_fetch,
      input  fetch_valid
   );

endinterface
`default_nettype wire

// File: rtl/fetch_sequencer_redirect_decode.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer_redirect_decode
// Purpose  : Combinational decode of an execute-stage control transfer.
//            Produces the redirect flag and the word-aligned target.
// Ports    : sel_i      - PC select from execute (seq/branch/JAL/JALR)
//            branch_i   - branch condition taken
//            target_i   - resolved target address
//            redirect_o - control flow leaves the sequential path
//            target_o   - target with the two low bits forced to zero
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer_redirect_decode
   import fetch_sequencer_pkg::*;
#(
   parameter int ADDRESS_BITS = 20
) (
   input  logic [1:0]              sel_i,
   input  logic                    branch_i,
   input  logic [ADDRESS_BITS-1:0] target_i,
   output logic                    redirect_o,
   output logic [ADDRESS_BITS-1:0] target_o
);

   localparam logic [ADDRESS_BITS-1:0] ALIGN_MASK = {{(ADDRESS_BITS-2){1'b1}}, 2'b00};

   pc_sel_e sel;
   assign sel = pc_sel_e'(sel_i);

   always_comb begin
      // A conditional branch only redirects when taken; jumps always do
      redirect_o = (sel == SEL_JALR) || (sel == SEL_JAL) ||
                   ((sel == SEL_BR) && branch_i);
      target_o   = target_i & ALIGN_MASK;
   end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Owns the fetch PC, drives the instruction-cache read port and
//            presents returned instructions to the fetch/decode register.
//            It keeps at most one cache request outstanding. Responses made
//            stale by an execute-stage redirect are dropped.
// Ports    : clock  - system clock
//            reset  - asynchronous, active-high reset
//            bus    - fetch_sequencer_if.master (stall, redirect inputs,
//                     icache request/response, fetch outputs)
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int                        DATA_WIDTH   = 32,
   parameter int                        ADDRESS_BITS = 20,
   parameter logic [ADDRESS_BITS-1:0]   RESET_PC     = '0
) (
   input  logic               clock,
   input  logic               reset,
   fetch_sequencer_if.master  bus
);

   localparam logic [DATA_WIDTH-1:0]   NOP_W  = DATA_WIDTH'(NOP);
   localparam logic [ADDRESS_BITS-1:0] PC_INC = ADDRESS_BITS'(4);

   fetch_state_e            state_q;
   logic [ADDRESS_BITS-1:0] pc_q;
   logic [ADDRESS_BITS-1:0] req_pc_q;
   logic [DATA_WIDTH-1:0]   hold_inst_q;

   logic                    redirect;
   logic [ADDRESS_BITS-1:0] redirect_target;

   fetch_sequencer_redirect_decode #(
      .ADDRESS_BITS (ADDRESS_BITS)
   ) u_redirect_decode (
      .sel_i      (bus.next_PC_select_execute),
      .branch_i   (bus.branch_execute),
      .target_i   (bus.redirect_target_execute),
      .redirect_o (redirect),
      .target_o   (redirect_target)
   );

   // ------------------------------------------------------------------------
   // State and PC registers. A redirect always wins over stall and normal
   // progress, whatever state the sequencer is in.
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         req_pc_q    <= '0;
         hold_inst_q <= NOP_W;
      end else begin
         case (state_q)
            IDLE: begin
               // One bubble after reset release before the first request
               if (redirect) begin
                  pc_q <= redirect_target;
               end
               state_q <= REQ;
            end

            REQ: begin
               if (redirect) begin
                  pc_q <= redirect_target;
               end else if (!bus.stall && bus.icache_ready) begin
                  req_pc_q <= pc_q;
                  pc_q     <= pc_q + PC_INC;
                  state_q  <= WAIT;
               end
            end

            WAIT: begin
               if (bus.icache_valid) begin
                  if (redirect) begin
                     // Response belongs to the abandoned path
                     pc_q    <= redirect_target;
                     state_q <= REQ;
                  end else if (bus.stall) begin
                     // The pipeline register cannot take it yet, so keep it
                     hold_inst_q <= bus.icache_instruction;
                     state_q     <= HOLD;
                  end else begin
                     state_q <= REQ;
                  end
               end else if (redirect) begin
                  // Request still in flight: its response must be swallowed
                  pc_q    <= redirect_target;
                  state_q <= DRAIN;
               end
            end

            HOLD: begin
               if (redirect) begin
                  pc_q    <= redirect_target;
                  state_q <= REQ;
               end else if (!bus.stall) begin
                  state_q <= REQ;
               end
            end

            DRAIN: begin
               if (redirect) begin
                  pc_q <= redirect_target;
               end
               if (bus.icache_valid) begin
                  state_q <= REQ;
               end
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs. fetch_valid follows the response in the same cycle so that
   // the cache latency equals the fetch latency. All outputs go quiet as
   // soon as reset forces the state back to IDLE.
   // ------------------------------------------------------------------------
   always_comb begin
      bus.icache_read       = 1'b0;
      bus.icache_address    = '0;
      bus.fetch_valid       = 1'b0;
      bus.instruction_fetch = NOP_W;
      bus.inst_PC_fetch     = '0;

      case (state_q)
         REQ: begin
            if (!redirect && !bus.stall) begin
               bus.icache_read    = 1'b1;
               bus.icache_address = pc_q;
            end
         end

         WAIT: begin
            if (bus.icache_valid && !redirect && !bus.stall) begin
               bus.fetch_valid       = 1'b1;
               bus.instruction_fetch = bus.icache_instruction;
               bus.inst_PC_fetch     = req_pc_q;
            end
         end

         HOLD: begin
            if (!redirect) begin
               bus.fetch_valid       = 1'b1;
               bus.instruction_fetch = hold_inst_q;
               bus.inst_PC_fetch     = req_pc_q;
            end
         end

         default: begin
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Purpose  : Self-checking bench for fetch_sequencer. Accepted requests push
//            the expected {PC, instruction} into a scoreboard. Presented
//            instructions pop and compare against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;
   import fetch_sequencer_pkg::*;

   localparam int AB = 20;
   localparam int DW = 32;

   typedef struct packed {
      logic [AB-1:0] pc;
      logic [DW-1:0] inst;
   } exp_t;

   logic clock;
   logic reset;

   fetch_sequencer_if #(.DATA_WIDTH(DW), .ADDRESS_BITS(AB)) bus ();

   fetch_sequencer #(
      .DATA_WIDTH   (DW),
      .ADDRESS_BITS (AB),
      .RESET_PC     (20'h0)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];
   exp_t e;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [DW-1:0] inst_for(input logic [AB-1:0] a);
      return 32'hA500_0000 | {12'h000, a};
   endfunction

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      @(negedge clock);
      checks++;
      if ({bus.icache_read, bus.icache_address, bus.fetch_valid, bus.inst_PC_fetch} !== 42'd0) begin
         failures++;
         $display("FAIL reset_outputs: read=%b addr=%h fv=%b pc=%h required all zero",
                  bus.icache_read, bus.icache_address, bus.fetch_valid, bus.inst_PC_fetch);
      end
      checks++;
      if (bus.instruction_fetch !== 32'h0000_0013) begin
         failures++;
         $display("FAIL reset_inst: got %h required 00000013", bus.instruction_fetch);
      end
      next_cycle();
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if (bus.icache_read !== 1'b0) begin
         failures++;
         $display("FAIL idle_bubble: icache_read=%b required 0", bus.icache_read);
      end
      next_cycle();
   endtask

   // ------------------------------------------------------------------------
   task automatic test_sequential();
      logic [AB-1:0] exp_pc;
      exp_pc = 20'h0;
      bus.icache_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         checks++;
         if (bus.icache_read !== 1'b1 || bus.icache_address !== exp_pc) begin
            failures++;
            $display("FAIL seq_request: read=%b addr=%h required read=1 addr=%h",
                     bus.icache_read, bus.icache_address, exp_pc);
         end
         sb.push_back('{pc: exp_pc, inst: inst_for(exp_pc)});
         next_cycle();
         bus.icache_valid       = 1'b1;
         bus.icache_instruction = inst_for(exp_pc);
         @(negedge clock);
         checks++;
         if (bus.fetch_valid !== 1'b1 || sb.size() == 0) begin
            failures++;
            $display("FAIL seq_present: fetch_valid=%b queued=%0d required fetch_valid=1",
                     bus.fetch_valid, sb.size());
         end else begin
            e = sb.pop_front();
            checks++;
            if (bus.inst_PC_fetch !== e.pc || bus.instruction_fetch !== e.inst) begin
               failures++;
               $display("FAIL seq_data: pc=%h inst=%h required pc=%h inst=%h",
                        bus.inst_PC_fetch, bus.instruction_fetch, e.pc, e.inst);
            end
         end
         checks++;
         if (bus.icache_read !== 1'b0) begin
            failures++;
            $display("FAIL seq_wait_read: icache_read=%b required 0", bus.icache_read);
         end
         next_cycle();
         bus.icache_valid = 1'b0;
         exp_pc = exp_pc + 20'd4;
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_not_ready();
      bus.icache_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         checks++;
         if (bus.icache_read !== 1'b1 || bus.icache_address !== 20'h10 || dut.pc_q !== 20'h10) begin
            failures++;
            $display("FAIL notready_retry: read=%b addr=%h pc=%h required read=1 addr=00010 pc=00010",
                     bus.icache_read, bus.icache_address, dut.pc_q);
         end
         next_cycle();
      end
      bus.icache_ready = 1'b1;
      @(negedge clock);
      checks++;
      if (bus.icache_read !== 1'b1 || bus.icache_address !== 20'h10) begin
         failures++;
         $display("FAIL notready_accept: read=%b addr=%h required read=1 addr=00010",
                  bus.icache_read, bus.icache_address);
      end
      sb.push_back('{pc: 20'h10, inst: inst_for(20'h10)});
      next_cycle();
      bus.icache_valid       = 1'b1;
      bus.icache_instruction = inst_for(20'h10);
      @(negedge clock);
      checks++;
      if (dut.pc_q !== 20'h14) begin
         failures++;
         $display("FAIL notready_pc_advance: pc=%h required 00014", dut.pc_q);
      end
      checks++;
      if (bus.fetch_valid !== 1'b1 || sb.size() == 0) begin
         failures++;
         $display("FAIL notready_present: fetch_valid=%b required 1", bus.fetch_valid);
      end else begin
         e = sb.pop_front();
         checks++;
         if (bus.inst_PC_fetch !== e.pc || bus.instruction_fetch !== e.inst) begin
            failures++;
            $display("FAIL notready_data: pc=%h inst=%h required pc=%h inst=%h",
                     bus.inst_PC_fetch, bus.instruction_fetch, e.pc, e.inst);
         end
      end
      next_cycle();
      bus.icache_valid = 1'b0;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_stall_hold();
      @(negedge clock);
      checks++;
      if (bus.icache_read !== 1'b1 || bus.icache_address !== 20'h14) begin
         failures++;
         $display("FAIL hold_request: read=%b addr=%h required read=1 addr=00014",
                  bus.icache_read, bus.icache_address);
      end
      sb.push_back('{pc: 20'h14, inst: 32'hDEAD_BEEF});
      next_cycle();
      bus.icache_valid       = 1'b1;
      bus.icache_instruction = 32'hDEAD_BEEF;
      bus.stall              = 1'b1;
      @(negedge clock);
      checks++;
      if (bus.fetch_valid !== 1'b0) begin
         failures++;
         $display("FAIL hold_capture_valid: fetch_valid=%b required 0", bus.fetch_valid);
      end
      next_cycle();
      bus.icache_valid       = 1'b0;
      bus.icache_instruction = 32'h0;
      @(negedge clock);
      checks++;
      if (dut.state_q !== HOLD) begin
         failures++;
         $display("FAIL hold_state: state=%0d required %0d", dut.state_q, HOLD);
      end
      checks++;
      if (bus.fetch_valid !== 1'b1 || sb.size() == 0 ||
          bus.instruction_fetch !== sb[0].inst || bus.inst_PC_fetch !== sb[0].pc) begin
         failures++;
         $display("FAIL hold_present_stalled: fv=%b pc=%h inst=%h required fv=1 pc=00014 inst=deadbeef",
                  bus.fetch_valid, bus.inst_PC_fetch, bus.instruction_fetch);
      end
      next_cycle();
      bus.stall = 1'b0;
      @(negedge clock);
      checks++;
      if (bus.fetch_valid !== 1'b1 || sb.size() == 0) begin
         failures++;
         $display("FAIL hold_release: fetch_valid=%b required 1", bus.fetch_valid);
      end else begin
         e = sb.pop_front();
         checks++;
         if (bus.inst_PC_fetch !== e.pc || bus.instruction_fetch !== e.inst) begin
            failures++;
            $display("FAIL hold_data: pc=%h inst=%h required pc=%h inst=%h",
                     bus.inst_PC_fetch, bus.instruction_fetch, e.pc, e.inst);
         end
      end
      next_cycle();
   endtask

   // ------------------------------------------------------------------------
   task automatic test_redirect_wait();
      @(negedge clock);
      checks++;
      if (bus.icache_read !== 1'b1 || bus.icache_address !== 20'h18) begin
         failures++;
         $display("FAIL redir_request: read=%b addr=%h required read=1 addr=00018",
                  bus.icache_read, bus.icache_address);
      end
      next_cycle();
      bus.next_PC_select_execute  = 2'b11;
      bus.redirect_target_execute = 20'h123;
      @(negedge clock);
      next_cycle();
      bus.next_PC_select_execute  = 2'b00;
      bus.redirect_target_execute = 20'h0;
      @(negedge clock);
      checks++;
      if (dut.state_q !== DRAIN || bus.icache_read !== 1'b0) begin
         failures++;
         $display("FAIL redir_drain: state=%0d read=%b required state=%0d read=0",
                  dut.state_q, bus.icache_read, DRAIN);
      end
      next_cycle();
      bus.icache_valid       = 1'b1;
      bus.icache_instruction = 32'hAAAA_0013;
      @(negedge clock);
      checks++;
      if (bus.fetch_valid !== 1'b0 || bus.instruction_fetch !== 32'h0000_0013) begin
         failures++;
         $display("FAIL redir_discard: fv=%b inst=%h required fv=0 inst=00000013",
                  bus.fetch_valid, bus.instruction_fetch);
      end
      next_cycle();
      bus.icache_valid = 1'b0;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_branch();
      @(negedge clock);
      checks++;
      if (bus.icache_read !== 1'b1 || bus.icache_address !== 20'h120) begin
         failures++;
         $display("FAIL branch_target_req: read=%b addr=%h required read=1 addr=00120",
                  bus.icache_read, bus.icache_address);
      end
      sb.push_back('{pc: 20'h120, inst: inst_for(20'h120)});
      next_cycle();
      bus.next_PC_select_execute  = 2'b01;
      bus.branch_execute          = 1'b0;
      bus.redirect_target_execute = 20'h300;
      bus.icache_valid            = 1'b1;
      bus.icache_instruction      = inst_for(20'h120);
      @(negedge clock);
      checks++;
      if (bus.fetch_valid !== 1'b1 || sb.size() == 0) begin
         failures++;
         $display("FAIL branch_not_taken: fetch_valid=%b required 1", bus.fetch_valid);
      end else begin
         e = sb.pop_front();
         checks++;
         if (bus.inst_PC_fetch !== e.pc || bus.instruction_fetch !== e.inst) begin
            failures++;
            $display("FAIL branch_nt_data: pc=%h inst=%h required pc=%h inst=%h",
                     bus.inst_PC_fetch, bus.instruction_fetch, e.pc, e.inst);
         end
      end
      next_cycle();
      bus.icache_valid           = 1'b0;
      bus.next_PC_select_execute = 2'b00;
      @(negedge clock);
      checks++;
      if (bus.icache_read !== 1'b1 || bus.icache_address !== 20'h124) begin
         failures++;
         $display("FAIL branch_seq_req: read=%b addr=%h required read=1 addr=00124",
                  bus.icache_read, bus.icache_address);
      end
      next_cycle();
      bus.next_PC_select_execute  = 2'b01;
      bus.branch_execute          = 1'b1;
      bus.redirect_target_execute = 20'h302;
      bus.icache_valid            = 1'b1;
      bus.icache_instruction      = inst_for(20'h124);
      @(negedge clock);
      checks++;
      if (bus.fetch_valid !== 1'b0) begin
         failures++;
         $display("FAIL branch_taken_discard: fetch_valid=%b required 0", bus.fetch_valid);
      end
      next_cycle();
      bus.icache_valid            = 1'b0;
      bus.next_PC_select_execute  = 2'b00;
      bus.branch_execute          = 1'b0;
      bus.redirect_target_execute = 20'h0;
      @(negedge clock);
      checks++;
      if (bus.icache_read !== 1'b1 || bus.icache_address !== 20'h300) begin
         failures++;
         $display("FAIL branch_aligned_target: read=%b addr=%h required read=1 addr=00300",
                  bus.icache_read, bus.icache_address);
      end
      next_cycle();
   endtask

   // ------------------------------------------------------------------------
   task automatic test_async_reset();
      // Request at 0x300 was accepted on the last edge: now in WAIT
      bus.icache_valid       = 1'b1;
      bus.icache_instruction = 32'h1111_1111;
      #1;
      checks++;
      if (bus.fetch_valid !== 1'b1 || bus.inst_PC_fetch !== 20'h300) begin
         failures++;
         $display("FAIL areset_pre: fv=%b pc=%h required fv=1 pc=00300",
                  bus.fetch_valid, bus.inst_PC_fetch);
      end
      #1;
      reset = 1'b1;
      #1;
      checks++;
      if (bus.fetch_valid !== 1'b0 || bus.icache_read !== 1'b0 || bus.inst_PC_fetch !== 20'h0 ||
          bus.instruction_fetch !== 32'h0000_0013 || dut.state_q !== IDLE) begin
         failures++;
         $display("FAIL areset_clear: fv=%b read=%b pc=%h inst=%h state=%0d required 0/0/00000/00000013/IDLE",
                  bus.fetch_valid, bus.icache_read, bus.inst_PC_fetch, bus.instruction_fetch, dut.state_q);
      end
      bus.icache_valid = 1'b0;
      next_cycle();
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if (dut.state_q !== IDLE || bus.icache_read !== 1'b0) begin
         failures++;
         $display("FAIL areset_idle: state=%0d read=%b required IDLE read=0",
                  dut.state_q, bus.icache_read);
      end
      next_cycle();
      bus.icache_ready       = 1'b0;
      bus.icache_valid       = 1'b1;
      bus.icache_instruction = 32'h2222_2222;
      @(negedge clock);
      checks++;
      if (bus.fetch_valid !== 1'b0 || bus.icache_read !== 1'b1 || bus.icache_address !== 20'h0) begin
         failures++;
         $display("FAIL areset_stale: fv=%b read=%b addr=%h required fv=0 read=1 addr=00000",
                  bus.fetch_valid, bus.icache_read, bus.icache_address);
      end
      next_cycle();
      bus.icache_valid = 1'b0;
      bus.icache_ready = 1'b1;
      @(negedge clock);
      sb.push_back('{pc: 20'h0, inst: inst_for(20'h0)});
      next_cycle();
      bus.icache_valid       = 1'b1;
      bus.icache_instruction = inst_for(20'h0);
      @(negedge clock);
      checks++;
      if (bus.fetch_valid !== 1'b1 || sb.size() == 0) begin
         failures++;
         $display("FAIL areset_refetch: fetch_valid=%b required 1", bus.fetch_valid);
      end else begin
         e = sb.pop_front();
         checks++;
         if (bus.inst_PC_fetch !== e.pc || bus.instruction_fetch !== e.inst) begin
            failures++;
            $display("FAIL areset_data: pc=%h inst=%h required pc=%h inst=%h",
                     bus.inst_PC_fetch, bus.instruction_fetch, e.pc, e.inst);
         end
      end
      next_cycle();
      bus.icache_valid = 1'b0;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_empty: %0d entries left required 0", sb.size());
      end
   endtask

   // ------------------------------------------------------------------------
   initial begin
      reset                       = 1'b1;
      bus.stall                   = 1'b0;
      bus.next_PC_select_execute  = 2'b00;
      bus.branch_execute          = 1'b0;
      bus.redirect_target_execute = '0;
      bus.icache_ready            = 1'b0;
      bus.icache_valid            = 1'b0;
      bus.icache_instruction      = '0;

      test_reset();
      test_sequential();
      test_not_ready();
      test_stall_hold();
      test_redirect_wait();
      test_branch();
      test_async_reset();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
`default_nettype wire
